// File: rtl/genesis_pad_pkg.sv
// Shared definitions for the Genesis pad scanner: button bit positions and scan FSM states.
package genesis_pad_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;
    localparam int BTN_W     = 12;

    localparam int PIN_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PHASE  = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchroniser for asynchronous pad pins; resets to the released (high) level.
module pad_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/genesis_pad_scanner.sv
// Active SEGA Genesis pad scanner: drives Select through the 3/6-button sequence,
// samples the synchronised pins and publishes a debounced active-high button vector.
module genesis_pad_scanner
    import genesis_pad_pkg::*;
#(
    parameter int POLL_DIV       = 833333,
    parameter int PHASE_CYCLES   = 500,
    parameter int SIX_BUTTON     = 1,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_z,
    input  logic             down_y,
    input  logic             left_x,
    input  logic             right,
    input  logic             a_b,
    input  logic             start_c,
    output logic             select_out,
    output logic [BTN_W-1:0] buttonsOut,
    output logic             pad_present,
    output logic             six_button,
    output logic             scan_valid
);

    localparam int POLL_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int CYC_W  = $clog2(PHASE_CYCLES);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(PHASE_CYCLES - 1);
    localparam logic [2:0]        LAST_PHASE = (SIX_BUTTON != 0) ? 3'd7 : 3'd1;
    localparam logic [3:0]        DB_LIMIT   = 4'(DEBOUNCE_SCANS);

    logic [PIN_W-1:0] raw_pins;
    logic [PIN_W-1:0] synced;
    logic             pin_up, pin_down, pin_left, pin_right, pin_ab, pin_sc;

    scan_state_t      state, state_next;
    logic [POLL_W-1:0] poll_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [2:0]       phase, phase_next;
    logic             select_next;
    logic             phase_end, last_phase;

    logic             present, six;
    logic [BTN_W-1:0] scan_vec;
    logic [BTN_W-1:0] prev_vec;
    logic [3:0]       stable_cnt, stable_next;

    assign raw_pins = {start_c, a_b, right, left_x, down_y, up_z};

    pad_sync #(.WIDTH(PIN_W)) u_pad_sync (
        .clk   (clk),
        .reset (reset),
        .din   (raw_pins),
        .dout  (synced)
    );

    // Pins are active-low; everything downstream works with pressed = 1.
    assign pin_up    = ~synced[0];
    assign pin_down  = ~synced[1];
    assign pin_left  = ~synced[2];
    assign pin_right = ~synced[3];
    assign pin_ab    = ~synced[4];
    assign pin_sc    = ~synced[5];

    assign phase_end  = (cyc_cnt == CYC_LAST);
    assign last_phase = (phase == LAST_PHASE);

    always_comb begin
        state_next  = state;
        phase_next  = phase;
        select_next = 1'b1;
        case (state)
            ST_IDLE: begin
                if (poll_cnt == POLL_LAST) begin
                    state_next = ST_PHASE;
                    phase_next = 3'd0;
                end
            end
            ST_PHASE: begin
                if (phase_end) begin
                    if (last_phase) begin
                        state_next = ST_COMMIT;
                    end else begin
                        phase_next = phase + 3'd1;
                    end
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Select is registered, so it is computed from the phase being entered.
        if (state_next == ST_PHASE) begin
            select_next = phase_next[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase      <= 3'd0;
            poll_cnt   <= '0;
            cyc_cnt    <= '0;
            select_out <= 1'b1;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            select_out <= select_next;
            case (state)
                ST_IDLE: begin
                    poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + POLL_W'(1);
                    cyc_cnt  <= '0;
                end
                ST_PHASE: begin
                    cyc_cnt <= phase_end ? '0 : cyc_cnt + CYC_W'(1);
                end
                default: begin
                    poll_cnt <= '0;
                    cyc_cnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            present  <= 1'b0;
            six      <= 1'b0;
            scan_vec <= '0;
        end else if (state == ST_IDLE && state_next == ST_PHASE) begin
            present  <= 1'b0;
            six      <= 1'b0;
            scan_vec <= '0;
        end else if (state == ST_PHASE && phase_end) begin
            case (phase)
                3'd0: begin
                    present            <= pin_left & pin_right;
                    scan_vec[BTN_A]     <= pin_ab;
                    scan_vec[BTN_START] <= pin_sc;
                end
                3'd1: begin
                    scan_vec[BTN_UP]    <= pin_up;
                    scan_vec[BTN_DOWN]  <= pin_down;
                    scan_vec[BTN_LEFT]  <= pin_left;
                    scan_vec[BTN_RIGHT] <= pin_right;
                    scan_vec[BTN_B]     <= pin_ab;
                    scan_vec[BTN_C]     <= pin_sc;
                end
                3'd4: begin
                    six <= pin_up & pin_down & pin_left & pin_right;
                end
                3'd5: begin
                    scan_vec[BTN_Z]    <= six & pin_up;
                    scan_vec[BTN_Y]    <= six & pin_down;
                    scan_vec[BTN_X]    <= six & pin_left;
                    scan_vec[BTN_MODE] <= six & pin_right;
                end
                default: ;
            endcase
        end
    end

    // Count of consecutive identical scans including this one, saturating at 15.
    always_comb begin
        stable_next = 4'd1;
        if (scan_vec == prev_vec) begin
            stable_next = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buttonsOut  <= '0;
            pad_present <= 1'b0;
            six_button  <= 1'b0;
            scan_valid  <= 1'b0;
            prev_vec    <= '0;
            stable_cnt  <= 4'd0;
        end else begin
            scan_valid <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                pad_present <= present;
                six_button  <= present & six;
                if (!present) begin
                    buttonsOut <= '0;
                    stable_cnt <= 4'd0;
                end else begin
                    stable_cnt <= stable_next;
                    prev_vec   <= scan_vec;
                    if (stable_next >= DB_LIMIT) begin
                        buttonsOut <= scan_vec;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Bench for genesis_pad_scanner: a 3-button build and a 6-button build, each with its own
// behavioural pad that follows Select, checked against a scan-level reference model.
module tb_genesis_pad_scanner;

    localparam int POLL_DIV       = 200;
    localparam int PHASE_CYCLES   = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int SCAN_TIMEOUT   = 1000;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_A = 4, B_B = 5;
    localparam int B_C = 6, B_START = 7, B_X = 8, B_Y = 9, B_Z = 10, B_MODE = 11;

    typedef enum int {PAD_NONE, PAD_3BTN, PAD_6BTN} pad_kind_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  pins0, pins1;
    logic        sel0, sel1, sv0, sv1, pres0, pres1, six0, six1;
    logic [11:0] btn0, btn1;
    logic [1:0]  sel, sv, pres, six;

    assign sel  = {sel1, sel0};
    assign sv   = {sv1, sv0};
    assign pres = {pres1, pres0};
    assign six  = {six1, six0};

    pad_kind_t   kind [2];
    logic [11:0] held [2];
    int          k0 = 0, k1 = 0;
    time         last0 = 0, last1 = 0;

    logic [11:0] exp_btn [2];
    logic        exp_pres [2];
    logic        exp_six [2];
    logic [11:0] last_vec [2];
    int          run_len [2];
    logic [11:0] model_vec;

    int compared = 0;
    int mismatched = 0;

    genesis_pad_scanner #(.POLL_DIV(POLL_DIV), .PHASE_CYCLES(PHASE_CYCLES), .SIX_BUTTON(0),
                          .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut3 (
        .clk(clk), .reset(reset),
        .up_z(pins0[0]), .down_y(pins0[1]), .left_x(pins0[2]), .right(pins0[3]),
        .a_b(pins0[4]), .start_c(pins0[5]),
        .select_out(sel0), .buttonsOut(btn0), .pad_present(pres0), .six_button(six0),
        .scan_valid(sv0)
    );

    genesis_pad_scanner #(.POLL_DIV(POLL_DIV), .PHASE_CYCLES(PHASE_CYCLES), .SIX_BUTTON(1),
                          .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut6 (
        .clk(clk), .reset(reset),
        .up_z(pins1[0]), .down_y(pins1[1]), .left_x(pins1[2]), .right(pins1[3]),
        .a_b(pins1[4]), .start_c(pins1[5]),
        .select_out(sel1), .buttonsOut(btn1), .pad_present(pres1), .six_button(six1),
        .scan_valid(sv1)
    );

    // Pad behaviour: k is the Select transition index since Select last sat still (>100 units).
    function automatic logic [5:0] pad_pins(pad_kind_t kd, logic [11:0] h, logic s, int k);
        logic [5:0] p;
        if (kd == PAD_NONE) return 6'h3F;
        if (s === 1'b1) begin
            if (kd == PAD_6BTN && k == 5) p = {h[B_C], h[B_B], h[B_MODE], h[B_X], h[B_Y], h[B_Z]};
            else p = {h[B_C], h[B_B], h[B_RIGHT], h[B_LEFT], h[B_DOWN], h[B_UP]};
        end else if (kd == PAD_6BTN && k == 4) begin
            p = {h[B_START], h[B_A], 4'b1111};
        end else begin
            p = {h[B_START], h[B_A], 2'b11, h[B_DOWN], h[B_UP]};
        end
        return ~p;
    endfunction

    function automatic logic [11:0] scan_vector(pad_kind_t kd, logic [11:0] h, bit six_dut);
        if (kd == PAD_NONE) return 12'h000;
        if (kd == PAD_6BTN && six_dut) return h;
        return h & 12'h0FF;
    endfunction

    function automatic logic [11:0] random_held();
        logic [11:0] h;
        h = 12'($urandom);
        if (h[B_UP]) h[B_DOWN] = 1'b0;
        if (h[B_LEFT]) h[B_RIGHT] = 1'b0;
        return h;
    endfunction

    function automatic logic [11:0] btn_of(int d);
        return (d == 0) ? btn0 : btn1;
    endfunction

    always @(sel0) begin
        if ($time - last0 > 100) k0 = 0; else k0 = k0 + 1;
        last0 = $time;
    end

    always @(sel1) begin
        if ($time - last1 > 100) k1 = 0; else k1 = k1 + 1;
        last1 = $time;
    end

    always_comb pins0 = pad_pins(kind[0], held[0], sel0, k0);
    always_comb pins1 = pad_pins(kind[1], held[1], sel1, k1);

    // Reference: a scan vector reaches the outputs once DEBOUNCE_SCANS identical scans in a row are seen.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                exp_btn[d] = 12'h000; exp_pres[d] = 1'b0; exp_six[d] = 1'b0;
                run_len[d] = 0; last_vec[d] = 12'h000;
            end else if (sv[d]) begin
                model_vec   = scan_vector(kind[d], held[d], d == 1);
                exp_pres[d] = (kind[d] != PAD_NONE);
                exp_six[d]  = (kind[d] == PAD_6BTN) && (d == 1);
                if (!exp_pres[d]) begin
                    run_len[d] = 0;
                    exp_btn[d] = 12'h000;
                end else begin
                    if (run_len[d] > 0 && model_vec == last_vec[d]) run_len[d] = run_len[d] + 1;
                    else run_len[d] = 1;
                    last_vec[d] = model_vec;
                    if (run_len[d] >= DEBOUNCE_SCANS) exp_btn[d] = model_vec;
                end
            end
        end
    end

    task automatic wait_scan(input int d, output int cycles, output int lows, output int falls);
        bit got, prev_sel;
        got = 1'b0; prev_sel = 1'b1; cycles = 0; lows = 0; falls = 0;
        while (!got && cycles < SCAN_TIMEOUT) begin
            @(negedge clk);
            cycles++;
            if (sel[d] === 1'b0) lows++;
            if (prev_sel && sel[d] === 1'b0) falls++;
            prev_sel = (sel[d] === 1'b1);
            if (sv[d] === 1'b1) got = 1'b1;
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL scan_timeout dut%0d: no scan_valid in %0d cycles, required one", d, cycles);
        end
        #1;
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (sel !== 2'b11) begin
            mismatched++; $display("[TB] FAIL reset_select: got %b, required 11", sel);
        end
        compared++;
        if (btn0 !== 12'h000 || btn1 !== 12'h000) begin
            mismatched++; $display("[TB] FAIL reset_buttons: got %h/%h, required 000/000", btn0, btn1);
        end
        compared++;
        if (pres !== 2'b00 || six !== 2'b00 || sv !== 2'b00) begin
            mismatched++; $display("[TB] FAIL reset_status: got pres=%b six=%b sv=%b, required 00", pres, six, sv);
        end
        reset = 1'b0;
        seen = 0;
        repeat (POLL_DIV) begin
            @(negedge clk);
            if (sv !== 2'b00) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++; $display("[TB] FAIL reset_quiet: got %0d scan_valid cycles, required 0", seen);
        end
    endtask

    task automatic test_three_button();
        int cyc, lows, falls;
        wait_scan(0, cyc, lows, falls);
        kind[0] = PAD_3BTN; held[0] = 12'h090;
        wait_scan(0, cyc, lows, falls);
        wait_scan(0, cyc, lows, falls);
        compared++;
        if (btn0 !== 12'h090 || btn0 !== exp_btn[0]) begin
            mismatched++; $display("[TB] FAIL three_buttons: got %h, required 090 (model %h)", btn0, exp_btn[0]);
        end
        compared++;
        if (pres0 !== 1'b1 || six0 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL three_status: got pres=%b six=%b, required 1/0", pres0, six0);
        end
        compared++;
        if (lows != PHASE_CYCLES || falls != 1) begin
            mismatched++; $display("[TB] FAIL three_phases: got %0d low cycles %0d falls, required %0d/1", lows, falls, PHASE_CYCLES);
        end
        compared++;
        if (cyc != POLL_DIV + 2 * PHASE_CYCLES + 1) begin
            mismatched++; $display("[TB] FAIL three_period: got %0d, required %0d", cyc, POLL_DIV + 2 * PHASE_CYCLES + 1);
        end
    endtask

    task automatic test_six_button();
        int cyc, lows, falls;
        wait_scan(1, cyc, lows, falls);
        kind[1] = PAD_6BTN; held[1] = 12'hC01;
        wait_scan(1, cyc, lows, falls);
        wait_scan(1, cyc, lows, falls);
        compared++;
        if (btn1 !== 12'hC01 || btn1 !== exp_btn[1]) begin
            mismatched++; $display("[TB] FAIL six_buttons: got %h, required C01 (model %h)", btn1, exp_btn[1]);
        end
        compared++;
        if (pres1 !== 1'b1 || six1 !== 1'b1) begin
            mismatched++; $display("[TB] FAIL six_status: got pres=%b six=%b, required 1/1", pres1, six1);
        end
        compared++;
        if (lows != 4 * PHASE_CYCLES || falls != 4) begin
            mismatched++; $display("[TB] FAIL six_phases: got %0d low cycles %0d falls, required %0d/4", lows, falls, 4 * PHASE_CYCLES);
        end
        compared++;
        if (cyc != POLL_DIV + 8 * PHASE_CYCLES + 1) begin
            mismatched++; $display("[TB] FAIL six_period: got %0d, required %0d", cyc, POLL_DIV + 8 * PHASE_CYCLES + 1);
        end
    endtask

    task automatic test_debounce();
        int cyc, lows, falls;
        held[0] = 12'h000;
        repeat (2) wait_scan(0, cyc, lows, falls);
        compared++;
        if (btn0 !== 12'h000) begin
            mismatched++; $display("[TB] FAIL debounce_idle: got %h, required 000", btn0);
        end
        for (int i = 0; i < 6; i++) begin
            held[0][B_C] = ~held[0][B_C];
            wait_scan(0, cyc, lows, falls);
            compared++;
            if (btn0[B_C] !== 1'b0 || btn0 !== exp_btn[0]) begin
                mismatched++; $display("[TB] FAIL debounce_toggle%0d: got %h, required bit6=0 (model %h)", i, btn0, exp_btn[0]);
            end
        end
        held[0][B_C] = 1'b1;
        wait_scan(0, cyc, lows, falls);
        compared++;
        if (btn0[B_C] !== 1'b0) begin
            mismatched++; $display("[TB] FAIL debounce_first: got bit6=%b, required 0", btn0[B_C]);
        end
        wait_scan(0, cyc, lows, falls);
        compared++;
        if (btn0[B_C] !== 1'b1 || btn0 !== exp_btn[0]) begin
            mismatched++; $display("[TB] FAIL debounce_held: got %h, required bit6=1 (model %h)", btn0, exp_btn[0]);
        end
    endtask

    task automatic test_unplug();
        int cyc, lows, falls;
        for (int d = 0; d < 2; d++) begin
            wait_scan(d, cyc, lows, falls);
            kind[d] = PAD_NONE;
            wait_scan(d, cyc, lows, falls);
            compared++;
            if (pres[d] !== 1'b0 || six[d] !== 1'b0 || btn_of(d) !== 12'h000) begin
                mismatched++;
                $display("[TB] FAIL unplug dut%0d: got pres=%b six=%b btn=%h, required 0/0/000", d, pres[d], six[d], btn_of(d));
            end
        end
    endtask

    task automatic test_random();
        int cyc, lows, falls;
        for (int i = 0; i < 12; i++) begin
            int d, n, r;
            d = i % 2;
            wait_scan(d, cyc, lows, falls);
            r = int'($urandom_range(0, 4));
            kind[d] = (r == 0) ? PAD_NONE : (r <= 2) ? PAD_3BTN : PAD_6BTN;
            held[d] = random_held();
            n = int'($urandom_range(1, 3));
            for (int j = 0; j < n; j++) begin
                wait_scan(d, cyc, lows, falls);
                compared++;
                if (btn_of(d) !== exp_btn[d] || pres[d] !== exp_pres[d] || six[d] !== exp_six[d]) begin
                    mismatched++;
                    $display("[TB] FAIL random%0d.%0d dut%0d: got btn=%h pres=%b six=%b, required %h/%b/%b",
                             i, j, d, btn_of(d), pres[d], six[d], exp_btn[d], exp_pres[d], exp_six[d]);
                end
            end
        end
    endtask

    task automatic test_midscan_reset();
        int cyc, lows, falls, n;
        wait_scan(1, cyc, lows, falls);
        kind[1] = PAD_6BTN; held[1] = random_held();
        n = 0;
        while (!(k1 == 3 && sel1 === 1'b1) && n < SCAN_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= SCAN_TIMEOUT) begin
            mismatched++; $display("[TB] FAIL phase3_timeout: waited %0d cycles, required phase 3", n);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (sel1 !== 1'b1 || sv !== 2'b00) begin
            mismatched++; $display("[TB] FAIL midscan_abort: got sel=%b sv=%b, required 1/00", sel1, sv);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_scan(1, cyc, lows, falls);
        compared++;
        if (cyc != POLL_DIV + 8 * PHASE_CYCLES + 1) begin
            mismatched++; $display("[TB] FAIL midscan_restart: got %0d cycles, required %0d", cyc, POLL_DIV + 8 * PHASE_CYCLES + 1);
        end
        compared++;
        if (btn1 !== 12'h000 || btn1 !== exp_btn[1]) begin
            mismatched++; $display("[TB] FAIL midscan_nocommit: got %h, required 000 (model %h)", btn1, exp_btn[1]);
        end
    endtask

    initial begin
        kind[0] = PAD_NONE; kind[1] = PAD_NONE;
        held[0] = 12'h000;  held[1] = 12'h000;
        test_reset();
        test_three_button();
        test_six_button();
        test_debounce();
        test_unplug();
        test_random();
        test_midscan_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
